pwm_sync_top: RTL
=================

# pwm_sync_top

Multi-channel PWM generator configured over the UDP user receive stream. It is the parametrised successor to the fixed five-channel PWM block. Period, high time and phase are programmed directly in clock cycles at a configurable counter width, and each channel has its own output polarity. Updates are double-buffered and take effect on a period boundary, so an enabled output never produces a truncated or glitched pulse. Malformed frames are rejected and flagged.

## Interface
- PWM_NUM, 8, number of PWM channels (1..256)
- ID_PWM_PARAM, 0, frame ID (tuser) that carries PWM parameters
- CNT_W, 32, width of the period/high/phase counters (2..32)

- clk  in  1  module clock
- rst  in  1  synchronous, active-high reset
- rx_axis_udp_tdata  in  32  UDP payload word
- rx_axis_udp_tvalid  in  1  word valid; no backpressure, every valid word is consumed
- rx_axis_udp_tlast  in  1  last word of frame
- rx_axis_udp_tuser  in  8  frame ID, constant across a frame
- pwm  out  PWM_NUM  PWM outputs, registered
- cfg_done  out  1  one-cycle pulse: a frame was accepted
- cfg_err  out  1  one-cycle pulse: a frame was rejected

## Operation
- Frame layout: exactly 5 words, with tuser == ID_PWM_PARAM on every word.
  - W0: [7:0] channel index, [8] polarity (0 = active-high, 1 = active-low).
  - W1: period, in cycles.
  - W2: high time, in cycles.
  - W3: phase, in cycles.
  - W4: [0] enable; tlast must be set on W4.
  - W1..W3 use bits [CNT_W-1:0]; upper bits are ignored.
- Words with tuser != ID_PWM_PARAM are ignored entirely and do not advance the parser.
- Parser states:
  - IDLE → W1 → W2 → W3 → W4, advancing one state per valid word.
  - Word index counter 0..4 is held in IDLE.
  - DROP: entered on an overlong frame; remains until a tlast word, then returns to IDLE without any further cfg_err.
- Rejection (cfg_err, no register change) for any of:
  - tlast on W0..W3 (short frame); return to IDLE.
  - tlast missing on W4; go to DROP.
  - channel >= PWM_NUM.
  - enable=1 with period < 2.
  - enable=1 with phase >= period.
  - Disable frames skip the period and phase checks.
- Accepted frame: written to the channel's pending register (pol, period, high, phase, en); pending_valid is set. A newer accepted frame overwrites any pending that has not yet been applied.
- Apply rule, per channel:
  - Channel currently disabled, or pending en=0: apply on the cycle after pending_valid is set.
  - Channel enabled: apply on the wrap cycle (cnt == period-1) only.
  - Applying clears pending_valid.
- Counter, per channel:
  - On apply from disabled to enabled, cnt loads phase.
  - On apply enabled to enabled, cnt wraps to 0 as usual, so the phase field is ignored in this case.
  - Otherwise cnt increments and wraps from period-1 to 0.
  - When disabled, cnt is held at 0.
- Output: active = en && (cnt < high); pwm = active XOR pol.
  - high == 0 gives a constant inactive level.
  - high >= period gives a constant active level (100% duty).
  - A disabled channel drives its inactive level, which equals pol.
- Width rule: all comparisons are unsigned at CNT_W bits; no arithmetic beyond the increment and compares.

## Timing
- Reset values:
  - pwm = 0, cfg_done = 0, cfg_err = 0.
  - All channels disabled with pol = 0, period = 0, high = 0, phase = 0, cnt = 0.
  - Parser in IDLE; all pending_valid cleared.
- W4 accepted at edge T: cfg_done or cfg_err is high during T+1, and pending is written at T+1.
- Disabled channel: active registers are loaded at T+2; pwm shows the first value (cnt = phase) at T+3.
- Enabled channel: pending is applied at the first wrap whose cycle is after T+1. If the wrap coincides with T+1, the update waits one full period.
- Steady state: pwm lags cnt by one cycle and has a period of exactly `period` cycles.
- Reset asserted mid-frame: the partial frame is discarded with no pulse. Words after reset deassertion are parsed from IDLE, so the trailing words of the interrupted frame are treated as a new short frame and produce cfg_err.
- Back-to-back frames with no idle cycle are supported. A frame addressed to the same channel as an unapplied pending overwrites that pending.

## Test plan
- Reset, then configure ch0 with period=100, high=50, phase=0, en=1 → cfg_done 1 cycle after W4; pwm[0] rises 3 cycles after W4; thereafter 50 cycles high / 50 low repeating.
- Configure ch1 with period=10 and high = 0, 10, 15 in turn → constant 0, then constant 1, then constant 1. Configure ch2 with pol=1, high=3 → 3 cycles low / 7 high.
- ch3 running with period=100, high=20; send period=40, high=10 mid-period → the old waveform completes its current period unbroken, then switches to 40/10 at the wrap.
- ch0 and ch1 both with period=8, high=4; ch1 phase=4, both enabled in the same frame sequence → ch1 output shifted 4 cycles relative to ch0 (accounting for the 6-cycle gap between frames).
- Error frames, each producing cfg_err, no cfg_done and no output change:
  - channel = PWM_NUM;
  - enable=1 with period=1;
  - phase = period;
  - tlast on W2;
  - a 7-word frame, which gives a single cfg_err.
- Assert rst for 1 cycle during W2 of a frame, then send a valid frame → the interrupted frame's W3–W4 give cfg_err, the following frame is accepted, and all pwm outputs are 0 after reset.

Source files
------------

// File: rtl/pwm_sync_top.sv
// Multi-channel PWM generator configured by 5-word frames on the UDP user receive stream.
// Updates are double-buffered per channel and take effect on a period boundary.
//
// state  | meaning
// S_IDLE | waiting for W0 (channel index, polarity)
// S_W1   | waiting for W1 (period)
// S_W2   | waiting for W2 (high time)
// S_W3   | waiting for W3 (phase)
// S_W4   | waiting for W4 (enable, must carry tlast)
// S_DROP | discarding the remainder of an overlong frame
module pwm_sync_top #(
  parameter int PWM_NUM      = 8,
  parameter int ID_PWM_PARAM = 0,
  parameter int CNT_W        = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        rx_axis_udp_tdata,
  input  logic               rx_axis_udp_tvalid,
  input  logic               rx_axis_udp_tlast,
  input  logic [7:0]         rx_axis_udp_tuser,
  output logic [PWM_NUM-1:0] pwm,
  output logic               cfg_done,
  output logic               cfg_err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_W1   = 3'd1;
  localparam logic [2:0] S_W2   = 3'd2;
  localparam logic [2:0] S_W3   = 3'd3;
  localparam logic [2:0] S_W4   = 3'd4;
  localparam logic [2:0] S_DROP = 3'd5;

  localparam logic [7:0]       LP_ID  = 8'(ID_PWM_PARAM);
  localparam logic [8:0]       LP_NUM = 9'(PWM_NUM);
  localparam logic [CNT_W-1:0] LP_TWO = CNT_W'(2);

  logic [2:0]       r_state;
  logic             r_done;
  logic             r_err;
  logic [7:0]       r_f_ch;
  logic             r_f_pol;
  logic [CNT_W-1:0] r_f_period;
  logic [CNT_W-1:0] r_f_high;
  logic [CNT_W-1:0] r_f_phase;
  logic             r_f_en;

  logic             w_beat;
  logic             w_last;
  logic [CNT_W-1:0] w_word;
  logic             w_bad;

  assign w_beat = rx_axis_udp_tvalid && (rx_axis_udp_tuser == LP_ID);
  assign w_last = rx_axis_udp_tlast;
  assign w_word = rx_axis_udp_tdata[CNT_W-1:0];

  // Disable frames only need a valid channel index.
  assign w_bad = ({1'b0, r_f_ch} >= LP_NUM) ||
                 (rx_axis_udp_tdata[0] && ((r_f_period < LP_TWO) || (r_f_phase >= r_f_period)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_f_ch     <= '0;
      r_f_pol    <= 1'b0;
      r_f_period <= '0;
      r_f_high   <= '0;
      r_f_phase  <= '0;
      r_f_en     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (w_beat) begin
        case (r_state)
          S_IDLE: begin
            r_f_ch  <= rx_axis_udp_tdata[7:0];
            r_f_pol <= rx_axis_udp_tdata[8];
            if (w_last) r_err <= 1'b1;
            else        r_state <= S_W1;
          end
          S_W1: begin
            r_f_period <= w_word;
            if (w_last) begin
              r_err   <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_W2;
            end
          end
          S_W2: begin
            r_f_high <= w_word;
            if (w_last) begin
              r_err   <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_W3;
            end
          end
          S_W3: begin
            r_f_phase <= w_word;
            if (w_last) begin
              r_err   <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_W4;
            end
          end
          S_W4: begin
            if (!w_last) begin
              r_err   <= 1'b1;
              r_state <= S_DROP;
            end else begin
              r_state <= S_IDLE;
              if (w_bad) begin
                r_err <= 1'b1;
              end else begin
                r_done <= 1'b1;
                r_f_en <= rx_axis_udp_tdata[0];
              end
            end
          end
          S_DROP: begin
            if (w_last) r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign cfg_done = r_done;
  assign cfg_err  = r_err;

  // The captured frame fields stay stable for the cycle after r_done, when pending is loaded.
  for (genvar g = 0; g < PWM_NUM; g++) begin : g_ch
    logic             r_en;
    logic             r_pol;
    logic [CNT_W-1:0] r_per;
    logic [CNT_W-1:0] r_hi;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pwm;
    logic             r_p_valid;
    logic             r_p_en;
    logic             r_p_pol;
    logic [CNT_W-1:0] r_p_per;
    logic [CNT_W-1:0] r_p_hi;
    logic [CNT_W-1:0] r_p_ph;

    logic             w_wr;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_wrap;
    logic             w_apply;

    assign w_wr      = r_done && (r_f_ch == 8'(g));
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_wrap    = (w_cnt_inc == r_per);
    assign w_apply   = r_p_valid && (!r_en || !r_p_en || w_wrap);

    always_ff @(posedge clk) begin
      if (rst) begin
        r_en      <= 1'b0;
        r_pol     <= 1'b0;
        r_per     <= '0;
        r_hi      <= '0;
        r_cnt     <= '0;
        r_pwm     <= 1'b0;
        r_p_valid <= 1'b0;
        r_p_en    <= 1'b0;
        r_p_pol   <= 1'b0;
        r_p_per   <= '0;
        r_p_hi    <= '0;
        r_p_ph    <= '0;
      end else begin
        if (w_wr) begin
          r_p_valid <= 1'b1;
          r_p_en    <= r_f_en;
          r_p_pol   <= r_f_pol;
          r_p_per   <= r_f_period;
          r_p_hi    <= r_f_high;
          r_p_ph    <= r_f_phase;
        end else if (w_apply) begin
          r_p_valid <= 1'b0;
        end

        if (w_apply) begin
          r_en  <= r_p_en;
          r_pol <= r_p_pol;
          r_per <= r_p_per;
          r_hi  <= r_p_hi;
          // Phase only matters when starting from the disabled state.
          if (r_p_en && !r_en) r_cnt <= r_p_ph;
          else                 r_cnt <= '0;
        end else if (r_en) begin
          r_cnt <= w_wrap ? '0 : w_cnt_inc;
        end

        r_pwm <= (r_en && (r_cnt < r_hi)) ^ r_pol;
      end
    end

    assign pwm[g] = r_pwm;
  end

endmodule
